// File: rtl/pong_match_ctrl_if.sv
// Signal bundle between the pong match sequencer and the rest of the game.
// The environment side (frame timing, buttons, ball position) uses the master
// view. The match sequencer uses the slave view.
interface pong_match_ctrl_if #(
    parameter int SCORE_W = 4
) ();
    logic               frame_tick;
    logic               start;
    logic               pause;
    logic               ai_sel_l;
    logic               ai_sel_r;
    logic [9:0]         ball_x;
    logic [5:0]         ball_width;
    logic               round_reset;
    logic               run;
    logic               serve_dir;
    logic               ai_ctrl_l;
    logic               ai_ctrl_r;
    logic [SCORE_W-1:0] score_l;
    logic [SCORE_W-1:0] score_r;
    logic               winner;
    logic [2:0]         state;

    modport master (
        output frame_tick, start, pause, ai_sel_l, ai_sel_r, ball_x, ball_width,
        input  round_reset, run, serve_dir, ai_ctrl_l, ai_ctrl_r,
               score_l, score_r, winner, state
    );

    modport slave (
        input  frame_tick, start, pause, ai_sel_l, ai_sel_r, ball_x, ball_width,
        output round_reset, run, serve_dir, ai_ctrl_l, ai_ctrl_r,
               score_l, score_r, winner, state
    );
endinterface

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer. It steps through idle, serve countdown, rally, point
// pause and game over. It detects misses from the ball position and keeps the
// score. It latches the paddle AI modes once per match. Every output comes
// straight from a register.
module pong_match_ctrl #(
    parameter int SCREEN_W    = 640,
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_TICKS = 60,
    parameter int POINT_TICKS = 90,
    parameter int SCORE_W     = 4
) (
    input logic              clk,
    input logic              reset,
    pong_match_ctrl_if.slave mif
);
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SERVE = 3'd1;
    localparam logic [2:0] ST_RALLY = 3'd2;
    localparam logic [2:0] ST_POINT = 3'd3;
    localparam logic [2:0] ST_OVER  = 3'd4;

    localparam int CNT_MAX = (SERVE_TICKS > POINT_TICKS) ? SERVE_TICKS : POINT_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_SERVE = CNT_W'(SERVE_TICKS);
    localparam logic [CNT_W-1:0]   CNT_POINT = CNT_W'(POINT_TICKS);
    localparam logic [SCORE_W-1:0] SCORE_WIN = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
    localparam logic [10:0]        RIGHT_LIM = 11'(SCREEN_W);
    // Ball positions at or above this value are a ball that has moved past x=0.
    localparam logic [9:0]         WRAP_X    = 10'd960;

    // Increment a score, but stop at the counter maximum instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        logic [SCORE_W-1:0] r;
        if (v == SCORE_MAX) begin
            r = v;
        end else begin
            r = v + SCORE_W'(1);
        end
        return r;
    endfunction

    logic [2:0]         state_r,       state_nxt_s;
    logic [CNT_W-1:0]   cnt_r,         cnt_nxt_s;
    logic [SCORE_W-1:0] score_l_r,     score_l_nxt_s;
    logic [SCORE_W-1:0] score_r_r,     score_r_nxt_s;
    logic               serve_dir_r,   serve_dir_nxt_s;
    logic               ai_ctrl_l_r,   ai_ctrl_l_nxt_s;
    logic               ai_ctrl_r_r,   ai_ctrl_r_nxt_s;
    logic               winner_r,      winner_nxt_s;
    logic               run_r,         run_nxt_s;
    logic               round_reset_r, round_reset_nxt_s;
    logic               start_q_r;
    logic               start_rise_s;
    logic               tick_last_s;
    logic               left_miss_s;
    logic               right_miss_s;
    logic [10:0]        right_edge_s;

    assign start_rise_s = mif.start & ~start_q_r;
    assign tick_last_s  = mif.frame_tick & (cnt_r == CNT_ONE);
    assign right_edge_s = {1'b0, mif.ball_x} + {5'b0_0000, mif.ball_width};
    assign left_miss_s  = (mif.ball_x == 10'd0) || (mif.ball_x >= WRAP_X);
    assign right_miss_s = (right_edge_s >= RIGHT_LIM) && (mif.ball_x < WRAP_X);

    // Next-state, scoring and countdown logic for the match sequence.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        score_l_nxt_s   = score_l_r;
        score_r_nxt_s   = score_r_r;
        serve_dir_nxt_s = serve_dir_r;
        ai_ctrl_l_nxt_s = ai_ctrl_l_r;
        ai_ctrl_r_nxt_s = ai_ctrl_r_r;
        winner_nxt_s    = winner_r;
        case (state_r)
            ST_IDLE: begin
                if (start_rise_s) begin
                    score_l_nxt_s   = {SCORE_W{1'b0}};
                    score_r_nxt_s   = {SCORE_W{1'b0}};
                    ai_ctrl_l_nxt_s = mif.ai_sel_l;
                    ai_ctrl_r_nxt_s = mif.ai_sel_r;
                    serve_dir_nxt_s = 1'b1;
                    cnt_nxt_s       = CNT_SERVE;
                    state_nxt_s     = ST_SERVE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SERVE: begin
                if (tick_last_s) begin
                    cnt_nxt_s   = cnt_r - CNT_ONE;
                    state_nxt_s = ST_RALLY;
                end else if (mif.frame_tick) begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            ST_RALLY: begin
                if (mif.pause) begin
                    state_nxt_s = ST_RALLY;
                end else if (left_miss_s) begin
                    score_r_nxt_s   = sat_inc(score_r_r);
                    serve_dir_nxt_s = 1'b1;
                    cnt_nxt_s       = CNT_POINT;
                    state_nxt_s     = ST_POINT;
                end else if (right_miss_s) begin
                    score_l_nxt_s   = sat_inc(score_l_r);
                    serve_dir_nxt_s = 1'b0;
                    cnt_nxt_s       = CNT_POINT;
                    state_nxt_s     = ST_POINT;
                end else begin
                    state_nxt_s = ST_RALLY;
                end
            end
            ST_POINT: begin
                if (tick_last_s) begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                    if (score_l_r >= SCORE_WIN) begin
                        winner_nxt_s = 1'b1;
                        state_nxt_s  = ST_OVER;
                    end else if (score_r_r >= SCORE_WIN) begin
                        winner_nxt_s = 1'b0;
                        state_nxt_s  = ST_OVER;
                    end else begin
                        cnt_nxt_s   = CNT_SERVE;
                        state_nxt_s = ST_SERVE;
                    end
                end else if (mif.frame_tick) begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            ST_OVER: begin
                if (start_rise_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_OVER;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        // Motion and object recentring follow the state being entered, so they line up with it.
        run_nxt_s         = (state_nxt_s == ST_RALLY) && !mif.pause;
        round_reset_nxt_s = (state_nxt_s == ST_IDLE) ||
                            ((state_nxt_s == ST_SERVE) && (state_r != ST_SERVE));
    end

    // Register the match state, the counters and all outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            cnt_r         <= {CNT_W{1'b0}};
            score_l_r     <= {SCORE_W{1'b0}};
            score_r_r     <= {SCORE_W{1'b0}};
            serve_dir_r   <= 1'b1;
            ai_ctrl_l_r   <= 1'b0;
            ai_ctrl_r_r   <= 1'b0;
            winner_r      <= 1'b0;
            run_r         <= 1'b0;
            round_reset_r <= 1'b1;
            start_q_r     <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            cnt_r         <= cnt_nxt_s;
            score_l_r     <= score_l_nxt_s;
            score_r_r     <= score_r_nxt_s;
            serve_dir_r   <= serve_dir_nxt_s;
            ai_ctrl_l_r   <= ai_ctrl_l_nxt_s;
            ai_ctrl_r_r   <= ai_ctrl_r_nxt_s;
            winner_r      <= winner_nxt_s;
            run_r         <= run_nxt_s;
            round_reset_r <= round_reset_nxt_s;
            start_q_r     <= mif.start;
        end
    end

    assign mif.state       = state_r;
    assign mif.score_l     = score_l_r;
    assign mif.score_r     = score_r_r;
    assign mif.serve_dir   = serve_dir_r;
    assign mif.ai_ctrl_l   = ai_ctrl_l_r;
    assign mif.ai_ctrl_r   = ai_ctrl_r_r;
    assign mif.winner      = winner_r;
    assign mif.run         = run_r;
    assign mif.round_reset = round_reset_r;
endmodule
